// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM type, error-data default and address range check for dmem_arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hfa11_1eaf;
  function automatic logic addr_legal(input logic [31:0] addr, input int mem_bytes);
    return addr <= 32'(mem_bytes - 4);
  endfunction
endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// rr_picker: combinational round-robin select, search starts at rr_i and wraps; excl_i masks requesters out.
module rr_picker #(
  parameter int NREQ = 2,
  parameter int IW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [NREQ-1:0] excl_i,
  input  logic [IW-1:0]   rr_i,
  output logic            valid_o,
  output logic [NREQ-1:0] oh_o,
  output logic [IW-1:0]   idx_o
);
  logic [NREQ-1:0] cand, rot;
  int pos;
  assign cand = req_i & ~excl_i;
  assign rot = NREQ'({cand, cand} >> rr_i);
  // Scan from the far end so the candidate closest to rr_i is the last one written.
  always_comb begin
    valid_o = 1'b0;
    pos = 0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (rot[i]) begin
        valid_o = 1'b1;
        pos = int'(rr_i) + i;
      end
    idx_o = IW'(pos >= NREQ ? pos - NREQ : pos);
  end
  assign oh_o = valid_o ? NREQ'(1) << idx_o : '0;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin IDLE/ISSUE/RESP sharing of a single-port data memory with address range checking.
// Define DMEM_ARB_LOCK_EN to add lock_i, which regrants a locked requester back-to-back.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int          NREQ      = 2,
  parameter int          MEM_BYTES = 4096,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ-1:0]    we_i,
  input  logic [NREQ*32-1:0] addr_i,
  input  logic [NREQ*32-1:0] wdata_i,
`ifdef DMEM_ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock_i,
`endif
  output logic [NREQ-1:0]    gnt_o,
  output logic [NREQ-1:0]    rvalid_o,
  output logic               err_o,
  output logic [31:0]        rdata_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [31:0]        mem_addr_o,
  output logic [31:0]        mem_wdata_o,
  input  logic [31:0]        mem_rdata_i
);
  localparam int IW = NREQ > 2 ? 2 : 1;
  arb_state_e state_q, state_d;
  logic [IW-1:0] w_q, w_d, rr_q, rr_d, p_idx, sel;
  logic [NREQ-1:0] woh_q, woh_d, excl, p_oh, sel_oh;
  logic we_q, we_d, legal_q, legal_d, lock_q, lock_d, p_valid, relock, take;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] addr_a [NREQ];
  logic [31:0] wdata_a [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g] = addr_i[32*g +: 32];
    assign wdata_a[g] = wdata_i[32*g +: 32];
  end
  assign excl = state_q == RESP ? woh_q : '0;
  rr_picker #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i  (req_i),
    .excl_i (excl),
    .rr_i   (rr_q),
    .valid_o(p_valid),
    .oh_o   (p_oh),
    .idx_o  (p_idx)
  );
`ifdef DMEM_ARB_LOCK_EN
  assign relock = state_q == RESP && lock_i[w_q] && req_i[w_q];
`else
  assign relock = 1'b0;
`endif
  assign sel = relock ? w_q : p_idx;
  assign sel_oh = relock ? woh_q : p_oh;
  assign take = state_q != ISSUE && (relock || p_valid);
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    woh_d = woh_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    legal_d = legal_q;
    rr_d = rr_q;
    lock_d = lock_q;
    if (state_q == ISSUE) begin
      state_d = RESP;
      // A lock-regranted access leaves the rotation where it was.
      if (!lock_q) rr_d = w_q == IW'(NREQ - 1) ? '0 : w_q + 1'b1;
    end else if (take) begin
      state_d = ISSUE;
      w_d = sel;
      woh_d = sel_oh;
      we_d = we_i[sel];
      addr_d = addr_a[sel];
      wdata_d = wdata_a[sel];
      legal_d = addr_legal(addr_a[sel], MEM_BYTES);
      lock_d = relock;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      w_q <= '0;
      woh_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      legal_q <= 1'b0;
      rr_q <= '0;
      lock_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      woh_q <= woh_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      legal_q <= legal_d;
      rr_q <= rr_d;
      lock_q <= lock_d;
    end
  end
  assign gnt_o = state_q == ISSUE ? woh_q : '0;
  assign rvalid_o = state_q == RESP ? woh_q : '0;
  assign err_o = state_q == RESP && !legal_q;
  assign rdata_o = state_q != RESP || (legal_q && we_q) ? '0 : legal_q ? mem_rdata_i : ERR_DATA;
  assign mem_req_o = state_q == ISSUE && legal_q;
  assign mem_we_o = mem_req_o && we_q;
  assign mem_addr_o = mem_req_o ? addr_q : '0;
  assign mem_wdata_o = mem_req_o ? wdata_q : '0;
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between NREQ requesters (core LSU on port 0, DMA/debug on ports 1..NREQ-1).
- Round-robin arbitration with a per-transaction ISSUE/RESP sequence, matched to the memory's one-cycle registered read.
- Range-checks every address.
- Out-of-range accesses complete with an error and never reach the memory.

Parameters:
- NREQ, 2, number of requesters (2..4).
- MEM_BYTES, 4096, memory size in bytes; legal byte address range is 0..MEM_BYTES-4.
- ERR_DATA, 32'hfa11_1eaf, read data returned on error.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous reset, active-high.
- req_i  in  NREQ  per-requester access request.
- we_i  in  NREQ  per-requester write enable.
- addr_i  in  NREQ*32  per-requester byte address; slice k is bits [32k+31:32k].
- wdata_i  in  NREQ*32  per-requester write data.
- gnt_o  out  NREQ  one-cycle grant pulse.
- rvalid_o  out  NREQ  one-cycle completion pulse (read data valid / write ack).
- err_o  out  1  qualifies rvalid_o: address out of range.
- rdata_o  out  32  read data, shared by all requesters, valid with rvalid_o.
- mem_req_o  out  1  to memory mem_req_i.
- mem_we_o  out  1  to memory write_enable_i.
- mem_addr_o  out  32  to memory addr_i.
- mem_wdata_o  out  32  to memory write_data_i.
- mem_rdata_i  in  32  from memory read_data_o; registered, valid the cycle after mem_req_o.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset rst_i is synchronous, active-high.
- Reset values: state=IDLE; gnt_o=0; rvalid_o=0; err_o=0; rdata_o=0; all mem_* outputs=0; rr pointer=0 (requester 0 highest priority).
- Reset mid-transaction aborts it. No rvalid_o is produced for the aborted access.
- Requester rule: hold req/we/addr/wdata stable from assertion until its gnt_o pulse. It may change them freely afterwards.
- Arbitration (combinational, evaluated in IDLE and RESP):
  - Search starts at index rr and wraps modulo NREQ.
  - The first asserted req_i wins.
  - A requester whose transaction is currently in RESP is excluded during that RESP cycle.
- FSM:
  - IDLE: if any req, register winner w, we_i[w], addr_i[w], wdata_i[w] and legal=(addr<=MEM_BYTES-4) -> ISSUE. Otherwise stay.
  - ISSUE (1 cycle): gnt_o[w]=1. If legal: mem_req_o=1, mem_we_o=we, mem_addr_o=addr, mem_wdata_o=wdata. If illegal: mem_req_o=0. Always -> RESP. rr updates to (w+1) mod NREQ.
  - RESP (1 cycle): rvalid_o[w]=1.
    - Legal read: rdata_o=mem_rdata_i.
    - Write: rdata_o=0.
    - Illegal: err_o=1 and rdata_o=ERR_DATA, including illegal writes.
    - Exit: if an eligible req exists, arbitrate and capture -> ISSUE. Otherwise -> IDLE.
- Latency and throughput:
  - Read data appears 2 cycles after the first IDLE cycle with req.
  - Back-to-back throughput is one access per 2 cycles; first access costs 3.
- Output timing: all outputs are registered or decoded from registered state. There is no combinational path from req_i to any output.
- Boundaries:
  - addr = MEM_BYTES-4 is legal; MEM_BYTES-3 and above are illegal.
  - addr=0 is legal.
  - rr wraps from NREQ-1 to 0.
  - A requester that drops req before gnt is not served.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - Extra input port lock_i, width NREQ.
  - If lock_i[w] is high during RESP and req_i[w] is high, w is regranted next (RESP -> ISSUE for w) regardless of rr. This supports atomic read-modify-write sequences.
  - rr is frozen while locked.
- Without the macro: no lock_i port; pure round-robin.

Decomposition:
- Package dmem_arb_pkg:
  - typedef enum logic [1:0] {IDLE, ISSUE, RESP} arb_state_e.
  - localparam ERR_DATA default.
  - Function addr_legal().
- Sub-module rr_picker: combinational round-robin priority select.
  - Inputs: req vector, rr pointer, exclude mask.
  - Outputs: one-hot winner and its index.

Test Plan:
- Single read: req_i=01, we=0, addr0=0x10, memory[0x10..0x13] holds 0xDEADBEEF -> gnt_o=01 at cycle 1, mem_req_o=1 at cycle 1, rvalid_o=01 with rdata_o=32'hDEADBEEF at cycle 2, err_o=0.
- Contention: both req at cycle 0, rr=0 -> grant order 0,1,0,1 in cycles 1,3,5,7; each rvalid follows its grant by one cycle.
- Out of range: addr=MEM_BYTES-3 read -> mem_req_o stays 0, rvalid_o pulses with err_o=1 and rdata_o=32'hfa11_1eaf. A write to the same address -> memory unchanged.
- Boundary: write 0xCAFEF00D to MEM_BYTES-4, then read it back -> err_o=0, rdata_o=32'hCAFEF00D.
- Reset in ISSUE: assert rst_i during an ISSUE cycle -> next cycle all outputs 0, state IDLE, no rvalid_o; the next request is served with rr=0.
- Lock (DMEM_ARB_LOCK_EN): requester 1 holds lock and req with both requesters requesting -> requester 1 granted 3 times consecutively. Drop lock -> requester 0 granted next.
